// File: rtl/isq_sched.sv
`default_nettype none
// ============================================================================
// Module   : isq_sched
// Purpose  : Oldest-first issue scheduler for the 64-entry issue queue.
//            Each cycle it selects at most one ready entry for each of the
//            MULT, ALU1, ALU2 and ADDR function units. Grants are registered.
//            The registered grants drive the issue queue's wait-bit clear and
//            feed the register-file read stage.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            rdy_vec               - per-entry ready (valid, operands, !wait)
//            cls_mul/cls_adr/cls_br- per-entry class bits (mul > adr > br)
//            head_ptr              - index of the oldest entry
//            fun_rdy_frm_exe       - unit accept {ADDR, ALU2, ALU1, MULT}
//            fls_vld               - mispredict flush, cancels this pick
//            *_gnt_vld / *_gnt_idx - registered grant valid / entry index
//            clr_inst_wat          - one-hot OR of the registered grants
//            mul_busy              - multiplier occupancy counter nonzero
//            perf_iss_cnt/_stl_cnt - performance counters
// Options  : ISQ_SCHED_PERF_EN     - when defined, builds the performance
//                                    counters; otherwise both ports read 0
// Revision : 1.0 - initial release
// ============================================================================
module isq_sched #(
    parameter int ISQ_DEPTH        = 64,
    parameter int ISQ_IDX_BITS_NUM = 6,
    parameter int MUL_LAT          = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISQ_DEPTH-1:0]        rdy_vec,
    input  logic [ISQ_DEPTH-1:0]        cls_mul,
    input  logic [ISQ_DEPTH-1:0]        cls_adr,
    input  logic [ISQ_DEPTH-1:0]        cls_br,
    input  logic [ISQ_IDX_BITS_NUM-1:0] head_ptr,
    input  logic [3:0]                  fun_rdy_frm_exe,
    input  logic                        fls_vld,
    output logic                        mul_gnt_vld,
    output logic                        alu1_gnt_vld,
    output logic                        alu2_gnt_vld,
    output logic                        adr_gnt_vld,
    output logic [ISQ_IDX_BITS_NUM-1:0] mul_gnt_idx,
    output logic [ISQ_IDX_BITS_NUM-1:0] alu1_gnt_idx,
    output logic [ISQ_IDX_BITS_NUM-1:0] alu2_gnt_idx,
    output logic [ISQ_IDX_BITS_NUM-1:0] adr_gnt_idx,
    output logic [ISQ_DEPTH-1:0]        clr_inst_wat,
    output logic                        mul_busy,
    output logic [31:0]                 perf_iss_cnt,
    output logic [31:0]                 perf_stl_cnt
);

    // The counter only ever holds values up to MUL_LAT-1.
    localparam int                c_CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);

    // Returns {found, index} of the oldest set bit of cand. Walking from the
    // youngest age to the oldest lets the last hit win, so no found-chain.
    function automatic logic [ISQ_IDX_BITS_NUM:0] f_oldest(
        input logic [ISQ_DEPTH-1:0]        cand,
        input logic [ISQ_IDX_BITS_NUM-1:0] head
    );
        logic [ISQ_IDX_BITS_NUM-1:0] pos;
        logic [ISQ_IDX_BITS_NUM-1:0] sel;
        logic                        found;
        sel   = '0;
        found = 1'b0;
        for (int k = ISQ_DEPTH - 1; k >= 0; k--) begin
            pos = head + ISQ_IDX_BITS_NUM'(k);
            if (cand[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return {found, sel};
    endfunction

    logic [c_CNT_W-1:0]          r_mul_cnt;
    logic [ISQ_DEPTH-1:0]        w_gnt_mask;
    logic [ISQ_DEPTH-1:0]        w_elig;
    logic [ISQ_DEPTH-1:0]        w_alu1_set;
    logic [ISQ_DEPTH-1:0]        w_alu2_set;
    logic [ISQ_DEPTH-1:0]        w_alu1_hot;
    logic [ISQ_IDX_BITS_NUM:0]   w_mul_pick, w_adr_pick, w_alu1_pick, w_alu2_pick;
    logic                        w_mul_gnt, w_adr_gnt, w_alu1_gnt, w_alu2_gnt;
    logic                        w_alu1_take;

    // The decoded registered grants double as the mask of entries granted
    // last cycle whose wait bits are only now being set.
    always_comb begin
        w_gnt_mask = '0;
        if (mul_gnt_vld)  w_gnt_mask[mul_gnt_idx]  = 1'b1;
        if (alu1_gnt_vld) w_gnt_mask[alu1_gnt_idx] = 1'b1;
        if (alu2_gnt_vld) w_gnt_mask[alu2_gnt_idx] = 1'b1;
        if (adr_gnt_vld)  w_gnt_mask[adr_gnt_idx]  = 1'b1;
    end
    assign clr_inst_wat = w_gnt_mask;

    assign w_elig = rdy_vec & ~w_gnt_mask;

    // Class priority mul > adr > br: the adr candidates exclude mul entries.
    // Branches sit in the ALU1 set but never in the ALU2 set.
    assign w_alu1_set = w_elig & ~cls_mul & ~cls_adr;
    assign w_mul_pick  = f_oldest(w_elig & cls_mul, head_ptr);
    assign w_adr_pick  = f_oldest(w_elig & cls_adr & ~cls_mul, head_ptr);
    assign w_alu1_pick = f_oldest(w_alu1_set, head_ptr);

    // ALU2 only loses ALU1's candidate when ALU1 is actually taking it.
    assign w_alu1_take = w_alu1_pick[ISQ_IDX_BITS_NUM] & fun_rdy_frm_exe[1];
    assign w_alu1_hot  = w_alu1_take ? (ISQ_DEPTH'(1) << w_alu1_pick[ISQ_IDX_BITS_NUM-1:0])
                                     : '0;
    assign w_alu2_set  = w_alu1_set & ~cls_br & ~w_alu1_hot;
    assign w_alu2_pick = f_oldest(w_alu2_set, head_ptr);

    assign w_mul_gnt  = w_mul_pick[ISQ_IDX_BITS_NUM] & fun_rdy_frm_exe[0]
                      & (r_mul_cnt == '0) & ~fls_vld;
    assign w_alu1_gnt = w_alu1_take & ~fls_vld;
    assign w_alu2_gnt = w_alu2_pick[ISQ_IDX_BITS_NUM] & fun_rdy_frm_exe[2] & ~fls_vld;
    assign w_adr_gnt  = w_adr_pick[ISQ_IDX_BITS_NUM] & fun_rdy_frm_exe[3] & ~fls_vld;

    // Grant registers. Indices hold when no grant is made, so a flush only
    // clears the valids. The occupancy counter keeps draining through a
    // flush because the multiply already issued is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_gnt_vld  <= 1'b0;
            alu1_gnt_vld <= 1'b0;
            alu2_gnt_vld <= 1'b0;
            adr_gnt_vld  <= 1'b0;
            mul_gnt_idx  <= '0;
            alu1_gnt_idx <= '0;
            alu2_gnt_idx <= '0;
            adr_gnt_idx  <= '0;
            r_mul_cnt    <= '0;
        end else begin
            mul_gnt_vld  <= w_mul_gnt;
            alu1_gnt_vld <= w_alu1_gnt;
            alu2_gnt_vld <= w_alu2_gnt;
            adr_gnt_vld  <= w_adr_gnt;
            if (w_mul_gnt)  mul_gnt_idx  <= w_mul_pick[ISQ_IDX_BITS_NUM-1:0];
            if (w_alu1_gnt) alu1_gnt_idx <= w_alu1_pick[ISQ_IDX_BITS_NUM-1:0];
            if (w_alu2_gnt) alu2_gnt_idx <= w_alu2_pick[ISQ_IDX_BITS_NUM-1:0];
            if (w_adr_gnt)  adr_gnt_idx  <= w_adr_pick[ISQ_IDX_BITS_NUM-1:0];
            if (w_mul_gnt)
                r_mul_cnt <= c_MUL_LOAD;
            else if (r_mul_cnt != '0)
                r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    assign mul_busy = (r_mul_cnt != '0);

`ifdef ISQ_SCHED_PERF_EN
    logic [31:0] r_perf_iss;
    logic [31:0] r_perf_stl;
    logic [2:0]  w_vld_num;

    assign w_vld_num = 3'(mul_gnt_vld) + 3'(alu1_gnt_vld)
                     + 3'(alu2_gnt_vld) + 3'(adr_gnt_vld);

    // A stall is a cycle with ready work where nothing becomes a grant
    // (a flushed pick counts as no pick).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_iss <= '0;
            r_perf_stl <= '0;
        end else begin
            r_perf_iss <= r_perf_iss + 32'(w_vld_num);
            if ((|rdy_vec) && !(w_mul_gnt | w_alu1_gnt | w_alu2_gnt | w_adr_gnt))
                r_perf_stl <= r_perf_stl + 32'd1;
        end
    end

    assign perf_iss_cnt = r_perf_iss;
    assign perf_stl_cnt = r_perf_stl;
`else
    assign perf_iss_cnt = '0;
    assign perf_stl_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_isq_sched
// Purpose  : Self-checking bench for isq_sched. Directed scenarios plus
//            randomized traffic, all compared each cycle against a
//            behavioural age-ordered scheduling model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isq_sched;
    localparam int D  = 64;
    localparam int IW = 6;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [D-1:0]  rdy_vec, cls_mul, cls_adr, cls_br;
    logic [IW-1:0] head_ptr;
    logic [3:0]    fun_rdy_frm_exe;
    logic          fls_vld;
    logic          mul_gnt_vld, alu1_gnt_vld, alu2_gnt_vld, adr_gnt_vld;
    logic [IW-1:0] mul_gnt_idx, alu1_gnt_idx, alu2_gnt_idx, adr_gnt_idx;
    logic [D-1:0]  clr_inst_wat;
    logic          mul_busy;
    logic [31:0]   perf_iss_cnt, perf_stl_cnt;

    always #5 clk = ~clk;

    isq_sched #(.ISQ_DEPTH(D), .ISQ_IDX_BITS_NUM(IW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .rdy_vec(rdy_vec), .cls_mul(cls_mul),
        .cls_adr(cls_adr), .cls_br(cls_br), .head_ptr(head_ptr),
        .fun_rdy_frm_exe(fun_rdy_frm_exe), .fls_vld(fls_vld),
        .mul_gnt_vld(mul_gnt_vld), .alu1_gnt_vld(alu1_gnt_vld),
        .alu2_gnt_vld(alu2_gnt_vld), .adr_gnt_vld(adr_gnt_vld),
        .mul_gnt_idx(mul_gnt_idx), .alu1_gnt_idx(alu1_gnt_idx),
        .alu2_gnt_idx(alu2_gnt_idx), .adr_gnt_idx(adr_gnt_idx),
        .clr_inst_wat(clr_inst_wat), .mul_busy(mul_busy),
        .perf_iss_cnt(perf_iss_cnt), .perf_stl_cnt(perf_stl_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model state. Unit numbering: 0 MULT, 1 ALU1, 2 ALU2, 3 ADDR.
    bit     m_vld[4];
    int     m_idx[4];
    int     m_cnt;
    longint m_iss, m_stl;

    task automatic model_step();
        bit  nv[4];
        int  ni[4];
        bit  masked[D];
        bit  any;
        int  e, nvld;
        if (rst) begin
            for (int u = 0; u < 4; u++) begin m_vld[u] = 0; m_idx[u] = 0; end
            m_cnt = 0; m_iss = 0; m_stl = 0;
        end else begin
            for (int i = 0; i < D; i++) masked[i] = 0;
            nvld = 0;
            for (int u = 0; u < 4; u++) begin
                if (m_vld[u]) begin masked[m_idx[u]] = 1; nvld++; end
                nv[u] = 0; ni[u] = m_idx[u];
            end
            // Visit entries oldest first; each claims the first free unit it may use.
            for (int age = 0; age < D; age++) begin
                e = (int'(head_ptr) + age) % D;
                if (rdy_vec[e] && !masked[e]) begin
                    if (cls_mul[e]) begin
                        if (fun_rdy_frm_exe[0] && m_cnt == 0 && !nv[0]) begin nv[0] = 1; ni[0] = e; end
                    end else if (cls_adr[e]) begin
                        if (fun_rdy_frm_exe[3] && !nv[3]) begin nv[3] = 1; ni[3] = e; end
                    end else if (cls_br[e]) begin
                        if (fun_rdy_frm_exe[1] && !nv[1]) begin nv[1] = 1; ni[1] = e; end
                    end else begin
                        if (fun_rdy_frm_exe[1] && !nv[1]) begin nv[1] = 1; ni[1] = e; end
                        else if (fun_rdy_frm_exe[2] && !nv[2]) begin nv[2] = 1; ni[2] = e; end
                    end
                end
            end
            if (fls_vld)
                for (int u = 0; u < 4; u++) begin nv[u] = 0; ni[u] = m_idx[u]; end
            any = nv[0] | nv[1] | nv[2] | nv[3];
            m_iss = m_iss + nvld;
            if (rdy_vec != 0 && !any) m_stl = m_stl + 1;
            if (nv[0]) m_cnt = ML - 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            for (int u = 0; u < 4; u++) begin m_vld[u] = nv[u]; m_idx[u] = ni[u]; end
        end
    endtask

    task automatic check_all();
        logic [63:0] exp_clr;
        logic [31:0] exp_iss, exp_stl;
        exp_clr = '0;
        for (int u = 0; u < 4; u++) if (m_vld[u]) exp_clr[m_idx[u]] = 1'b1;
`ifdef ISQ_SCHED_PERF_EN
        exp_iss = m_iss[31:0];
        exp_stl = m_stl[31:0];
`else
        exp_iss = 32'd0;
        exp_stl = 32'd0;
`endif
        chk("mul_vld",  64'(mul_gnt_vld),  64'(m_vld[0]));
        chk("alu1_vld", 64'(alu1_gnt_vld), 64'(m_vld[1]));
        chk("alu2_vld", 64'(alu2_gnt_vld), 64'(m_vld[2]));
        chk("adr_vld",  64'(adr_gnt_vld),  64'(m_vld[3]));
        chk("mul_idx",  64'(mul_gnt_idx),  64'(m_idx[0]));
        chk("alu1_idx", 64'(alu1_gnt_idx), 64'(m_idx[1]));
        chk("alu2_idx", 64'(alu2_gnt_idx), 64'(m_idx[2]));
        chk("adr_idx",  64'(adr_gnt_idx),  64'(m_idx[3]));
        chk("clr_wat",  clr_inst_wat,      exp_clr);
        chk("mul_busy", 64'(mul_busy),     64'(m_cnt != 0));
        chk("perf_iss", 64'(perf_iss_cnt), 64'(exp_iss));
        chk("perf_stl", 64'(perf_stl_cnt), 64'(exp_stl));
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next one.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic [D-1:0] r, input logic [D-1:0] m, input logic [D-1:0] a,
                          input logic [D-1:0] b, input logic [IW-1:0] h, input logic [3:0] f,
                          input logic fl);
        rst = 1'b0; rdy_vec = r; cls_mul = m; cls_adr = a; cls_br = b;
        head_ptr = h; fun_rdy_frm_exe = f; fls_vld = fl;
    endtask

    task automatic idle(input int n);
        set_in('0, '0, '0, '0, '0, 4'hF, 1'b0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    localparam logic [D-1:0] P_RDY = 64'h6A4;  // entries 2,5,7,9,10
    localparam logic [D-1:0] P_MUL = 64'h20;
    localparam logic [D-1:0] P_ADR = 64'h80;
    localparam logic [D-1:0] P_BR  = 64'h200;

    initial begin
        rst = 1'b1; rdy_vec = '0; cls_mul = '0; cls_adr = '0; cls_br = '0;
        head_ptr = '0; fun_rdy_frm_exe = '0; fls_vld = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_clr",  clr_inst_wat, 64'd0);
        chk("rst_busy", 64'(mul_busy), 64'd0);

        // Four-unit issue
        set_in(P_RDY, P_MUL, P_ADR, P_BR, 6'd0, 4'hF, 1'b0);
        cyc();
        chk("s1_mul_idx",  64'(mul_gnt_idx),  64'd5);
        chk("s1_adr_idx",  64'(adr_gnt_idx),  64'd7);
        chk("s1_alu1_idx", 64'(alu1_gnt_idx), 64'd2);
        chk("s1_alu2_idx", 64'(alu2_gnt_idx), 64'd10);
        chk("s1_clr",      clr_inst_wat,      64'h4A4);

        // Head wrap: 63 is older than 1 when head is 62
        idle(3);
        set_in((64'd1 << 63) | 64'd2, '0, '0, '0, 6'd62, 4'b0010, 1'b0);
        cyc();
        chk("wrap_vld", 64'(alu1_gnt_vld), 64'd1);
        chk("wrap_idx", 64'(alu1_gnt_idx), 64'd63);
        cyc();
        chk("wrap_next_idx", 64'(alu1_gnt_idx), 64'd1);

        // Multiplier occupancy; entry 4 drops out of rdy once granted
        idle(3);
        set_in(64'h50, 64'h50, '0, '0, 6'd0, 4'hF, 1'b0);
        cyc();
        chk("occ_g0_idx", 64'(mul_gnt_idx), 64'd4);
        chk("occ_g0_busy", 64'(mul_busy), 64'd1);
        set_in(64'h40, 64'h50, '0, '0, 6'd0, 4'hF, 1'b0);
        cyc();
        chk("occ_c1_vld", 64'(mul_gnt_vld), 64'd0);
        chk("occ_c1_busy", 64'(mul_busy), 64'd1);
        cyc();
        chk("occ_c2_vld", 64'(mul_gnt_vld), 64'd0);
        chk("occ_c2_busy", 64'(mul_busy), 64'd0);
        cyc();
        chk("occ_g1_vld", 64'(mul_gnt_vld), 64'd1);
        chk("occ_g1_idx", 64'(mul_gnt_idx), 64'd6);
        // Reset while the multiplier is occupied
        rst = 1'b1;
        cyc();
        chk("rst_mid_busy", 64'(mul_busy), 64'd0);

        // Branch routing: ALU2 never takes a branch; granted entry is masked
        set_in(64'h8, '0, '0, 64'h8, 6'd0, 4'b0100, 1'b0);
        cyc();
        chk("br_alu2_vld", 64'(alu2_gnt_vld), 64'd0);
        chk("br_alu1_vld", 64'(alu1_gnt_vld), 64'd0);
        fun_rdy_frm_exe = 4'b0010;
        cyc();
        chk("br_alu1_idx", 64'(alu1_gnt_idx), 64'd3);
        cyc();
        chk("br_no_regrant", 64'(alu1_gnt_vld), 64'd0);

        // Flush cancels every pick
        idle(3);
        set_in(P_RDY, P_MUL, P_ADR, P_BR, 6'd0, 4'hF, 1'b1);
        cyc();
        chk("fls_vlds", {60'd0, mul_gnt_vld, alu1_gnt_vld, alu2_gnt_vld, adr_gnt_vld}, 64'd0);

        // Ten cycles of the first pattern with a single flush cycle
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            set_in(P_RDY, P_MUL, P_ADR, P_BR, 6'd0, 4'hF, i == 4);
            cyc();
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst             = ($urandom_range(0, 149) == 0);
            rdy_vec         = {$urandom, $urandom} & {$urandom, $urandom} &
                              (($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1);
            cls_mul         = {$urandom, $urandom} & {$urandom, $urandom};
            cls_adr         = {$urandom, $urandom} & {$urandom, $urandom};
            cls_br          = {$urandom, $urandom} & {$urandom, $urandom};
            head_ptr        = IW'($urandom);
            fun_rdy_frm_exe = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            fls_vld         = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) rdy_vec = '0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
